// File: rtl/ib_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ib_lut_pkg
// Description : Shared definitions for the IB LUT loader and its memory:
//               controller state encoding, default LUT geometry and the
//               checksum width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package ib_lut_pkg;

  // Default LUT geometry, shared with the LUT memory instance.
  localparam int QUAN_SIZE_DEF     = 3;
  localparam int PAGE_NUM_DEF      = 16;
  localparam int ADDR_BITWIDTH_DEF = 4;

  // Loader controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Checksum width: at most 2^addr_w entries of quan_w bits each can be
  // summed without wrapping.
  function automatic int csum_w(input int quan_w, input int addr_w);
    return quan_w + addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ib_lut_csum_acc.sv
`default_nettype none
// ============================================================================
// Module      : ib_lut_csum_acc
// Description : Clearable, enabled modular (unsigned) accumulator used for
//               the write-side and read-side LUT checksums.
// Ports       : i_clk   - clock
//               i_rst_n - asynchronous active-low reset (clears accumulator)
//               i_clr   - synchronous clear, has priority over i_en
//               i_en    - add i_din on this edge
//               i_din   - addend (zero-extended)
//               o_acc   - current accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
module ib_lut_csum_acc #(
  parameter int ACC_W = 7,
  parameter int DIN_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIN_W-1:0] i_din,
  output logic [ACC_W-1:0] o_acc
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_din_ext;

  assign w_din_ext = {{(ACC_W-DIN_W){1'b0}}, i_din};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + w_din_ext;
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/ib_lut_loader.sv
`default_nettype none
// ============================================================================
// Module      : ib_lut_loader
// Description : Write-side controller for a single-port IB LUT memory.
//               Streams PAGE_NUM entries into pages 0..PAGE_NUM-1, reads
//               them back through the asynchronous read path, and compares
//               write and read checksums before declaring the LUT usable.
// Ports       : sys_clk     - clock, rising edge
//               rstn        - asynchronous active-low reset
//               start_i     - load request pulse (IDLE/DONE/ERR only)
//               data_i      - incoming LUT entry
//               valid_i     - data_i valid
//               ready_o     - entry accepted this cycle (LOAD only)
//               mem_we_o    - memory write enable
//               mem_addr_o  - shared memory address
//               mem_wdata_o - memory write data
//               mem_rdata_i - asynchronous read data at mem_addr_o
//               busy_o      - load or verify in progress
//               done_o      - load verified
//               err_o       - checksum mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module ib_lut_loader
  import ib_lut_pkg::*;
#(
  parameter int QUAN_SIZE     = QUAN_SIZE_DEF,
  parameter int PAGE_NUM      = PAGE_NUM_DEF,
  parameter int ADDR_BITWIDTH = ADDR_BITWIDTH_DEF
) (
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     start_i,
  input  logic [QUAN_SIZE-1:0]     data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     mem_we_o,
  output logic [ADDR_BITWIDTH-1:0] mem_addr_o,
  output logic [QUAN_SIZE-1:0]     mem_wdata_o,
  input  logic [QUAN_SIZE-1:0]     mem_rdata_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int                       C_CSUM_W = csum_w(QUAN_SIZE, ADDR_BITWIDTH);
  localparam logic [ADDR_BITWIDTH-1:0] C_LAST   = ADDR_BITWIDTH'(PAGE_NUM - 1);
  localparam logic [ADDR_BITWIDTH-1:0] C_ONE    = ADDR_BITWIDTH'(1);

  state_t                   r_state;
  logic [ADDR_BITWIDTH-1:0] r_cnt;
  // Set for the single cycle after the last read, when the read checksum
  // already includes the final page and the comparison is made.
  logic                     r_cmp;

  logic                     w_idle_like;
  logic                     w_start;
  logic                     w_load;
  logic                     w_verify;
  logic                     w_hs;
  logic                     w_rd;
  logic [C_CSUM_W-1:0]      w_wr_csum;
  logic [C_CSUM_W-1:0]      w_rd_csum;

  assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_start     = start_i && w_idle_like;
  assign w_load      = (r_state == ST_LOAD);
  assign w_verify    = (r_state == ST_VERIFY);
  assign w_hs        = valid_i && w_load;
  assign w_rd        = w_verify && !r_cmp;

  ib_lut_csum_acc #(
    .ACC_W (C_CSUM_W),
    .DIN_W (QUAN_SIZE)
  ) u_wr_csum (
    .i_clk   (sys_clk),
    .i_rst_n (rstn),
    .i_clr   (w_start),
    .i_en    (w_hs),
    .i_din   (data_i),
    .o_acc   (w_wr_csum)
  );

  ib_lut_csum_acc #(
    .ACC_W (C_CSUM_W),
    .DIN_W (QUAN_SIZE)
  ) u_rd_csum (
    .i_clk   (sys_clk),
    .i_rst_n (rstn),
    .i_clr   (w_start),
    .i_en    (w_rd),
    .i_din   (mem_rdata_i),
    .o_acc   (w_rd_csum)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cmp   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_cmp   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            if (r_cnt == C_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_VERIFY;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end
        end
        ST_VERIFY: begin
          if (!r_cmp) begin
            if (r_cnt == C_LAST) begin
              r_cnt <= '0;
              r_cmp <= 1'b1;
            end else begin
              r_cnt <= r_cnt + C_ONE;
            end
          end else begin
            r_cmp   <= 1'b0;
            r_state <= (w_wr_csum == w_rd_csum) ? ST_DONE : ST_ERR;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_cmp   <= 1'b0;
        end
      endcase
    end
  end

  // Write enable coincides with the handshake so the memory captures the
  // entry on the same edge the loader accepts it.
  assign ready_o     = w_load;
  assign mem_we_o    = w_hs;
  assign mem_addr_o  = (w_load || w_verify) ? r_cnt : '0;
  assign mem_wdata_o = w_load ? data_i : '0;
  assign busy_o      = w_load || w_verify;
  assign done_o      = (r_state == ST_DONE);
  assign err_o       = (r_state == ST_ERR);

endmodule
`default_nettype wire
